rf_wport_sched: RTL and testbench

//  Write-port scheduler and scoreboard for the 32x32 register file in the pipelined RV32I core.

---
 rtl/rf_wport_sched.sv | 154 +++++++++++++++
 tb/tb_rf_wport_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_sched.sv
// rf_wport_sched
//   Write-port scheduler and scoreboard for the 32x32 register file of the
//   pipelined RV32I core. The single RF write port is shared between the
//   in-order WB stage and the long-latency unit (LU: mul/div/load-miss).
//   Pending destination registers are tracked in busy_vec, and issue is
//   stalled on RAW/WAW hazards.
//
//   Optional feature macro: RF_SCHED_BYPASS_EN
//     defined   : a source register being written this cycle does not stall.
//                 fwd_rs1/fwd_rs2 tell decode to take rf_wD for that source.
//     undefined : no bypass. fwd_rs1/fwd_rs2 are tied to 0.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   issue_valid/rs1/rs2/rd/rd_we decode request; issue_stall holds decode
//   wb_valid/rd/data, wb_ready   WB write request and accept
//   lu_valid/rd/data, lu_ready   LU write request and accept
//   rf_wR/rf_we/rf_wD            register file write port
//   busy_vec                     bit i = a write to xi is pending
//   fwd_rs1/fwd_rs2              source satisfied by this cycle's rf_wD
//
// Handshakes: a requester raises *_valid and holds rd/data stable until it
// sees *_ready high. The write is accepted, and the RF is written, on the
// same rising edge where valid & ready are both high. Issue fires on an edge
// where issue_valid & !issue_stall.

module rf_wport_sched #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_rd_we,
  output logic            issue_stall,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic [4:0]      rf_wR,
  output logic            rf_we,
  output logic [XLEN-1:0] rf_wD,
  output logic [31:0]     busy_vec,
  output logic            fwd_rs1,
  output logic            fwd_rs2
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic          force_lu_q, force_lu_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]   busy_q, busy_d;

  logic wb_gnt, lu_gnt, any_gnt;
  logic hit_rs1, hit_rs2;
  logic issue_fire;

  // Arbitration: WB has priority unless LU has been starved long enough,
  // in which case WB is frozen for exactly one cycle. No grants in reset.
  always_comb begin
    wb_ready = ~rst & ~force_lu_q;
    lu_ready = ~rst & (force_lu_q | (lu_valid & ~wb_valid));
    wb_gnt   = wb_valid & wb_ready;
    lu_gnt   = lu_valid & lu_ready;
  end

  // Write-port mux. The grants are mutually exclusive by construction.
  always_comb begin
    rf_wR   = 5'd0;
    rf_wD   = '0;
    any_gnt = 1'b0;
    if (wb_gnt) begin
      rf_wR   = wb_rd;
      rf_wD   = wb_data;
      any_gnt = 1'b1;
    end else if (lu_gnt) begin
      rf_wR   = lu_rd;
      rf_wD   = lu_data;
      any_gnt = 1'b1;
    end
  end

  // x0 is hardwired, so a granted write to it is consumed without writing.
  assign rf_we = any_gnt & (rf_wR != 5'd0);

  // Starvation counter: counts consecutive cycles LU waits. Reaching
  // STARVE_MAX-1 while still waiting raises force_lu for the next cycle;
  // the forced grant then clears both the counter and force_lu.
  always_comb begin
    starve_cnt_d = '0;
    if (lu_valid & ~lu_ready) begin
      if (starve_cnt_q != CW'(STARVE_MAX))
        starve_cnt_d = starve_cnt_q + CW'(1);
      else
        starve_cnt_d = starve_cnt_q;
    end
    force_lu_d = (starve_cnt_q == CW'(STARVE_MAX - 1)) & lu_valid & ~lu_ready;
  end

`ifdef RF_SCHED_BYPASS_EN
  // A source being written this cycle is served from rf_wD.
  assign hit_rs1 = rf_we & (rf_wR == issue_rs1);
  assign hit_rs2 = rf_we & (rf_wR == issue_rs2);
  assign fwd_rs1 = issue_valid & hit_rs1;
  assign fwd_rs2 = issue_valid & hit_rs2;
`else
  assign hit_rs1 = 1'b0;
  assign hit_rs2 = 1'b0;
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
`endif

  // busy_q[0] is always 0, so x0 never stalls. WAW on rd ignores bypass:
  // the older write must land before a newer writer may be tracked.
  assign issue_stall = issue_valid &
                       ((busy_q[issue_rs1] & ~hit_rs1) |
                        (busy_q[issue_rs2] & ~hit_rs2) |
                        (issue_rd_we & busy_q[issue_rd]));

  assign issue_fire = issue_valid & ~issue_stall;

  // Scoreboard update: clear on write, then set on issue so that a set and
  // clear of the same register in one cycle leaves it pending.
  always_comb begin
    busy_d = busy_q;
    if (rf_we)
      busy_d[rf_wR] = 1'b0;
    if (issue_fire & issue_rd_we & (issue_rd != 5'd0))
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      starve_cnt_q <= '0;
      force_lu_q   <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      starve_cnt_q <= starve_cnt_d;
      force_lu_q   <= force_lu_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_wport_sched.sv
// tb_rf_wport_sched
//   Directed and random stimulus for rf_wport_sched. Every write that the
//   RF port is expected to perform is pushed to exp_q in grant order. A
//   monitor pops and compares on each observed rf_we.

module tb_rf_wport_sched;

  localparam int XLEN = 32;
  localparam int EW   = 5 + XLEN;

  logic            clk;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      issue_rs1, issue_rs2, issue_rd;
  logic            issue_rd_we;
  logic            issue_stall;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_ready;
  logic            lu_valid;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            lu_ready;
  logic [4:0]      rf_wR;
  logic            rf_we;
  logic [XLEN-1:0] rf_wD;
  logic [31:0]     busy_vec;
  logic            fwd_rs1, fwd_rs2;

  logic [EW-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  rf_wport_sched #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_rd_we (issue_rd_we),
    .issue_stall (issue_stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .lu_valid    (lu_valid),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .lu_ready    (lu_ready),
    .rf_wR       (rf_wR),
    .rf_we       (rf_we),
    .rf_wD       (rf_wD),
    .busy_vec    (busy_vec),
    .fwd_rs1     (fwd_rs1),
    .fwd_rs2     (fwd_rs2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic drive_idle();
    issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    issue_rd = 5'd0;    issue_rd_we = 1'b0;
    wb_valid = 1'b0;    wb_rd = 5'd0; wb_data = '0;
    lu_valid = 1'b0;    lu_rd = 5'd0; lu_data = '0;
  endtask

  task automatic drive_random();
    issue_valid = 1'($urandom_range(0, 1));
    issue_rs1   = 5'($urandom_range(0, 31));
    issue_rs2   = 5'($urandom_range(0, 31));
    issue_rd    = 5'($urandom_range(0, 31));
    issue_rd_we = 1'($urandom_range(0, 1));
    wb_valid    = 1'($urandom_range(0, 1));
    wb_rd       = 5'($urandom_range(0, 31));
    wb_data     = $urandom;
    lu_valid    = 1'($urandom_range(0, 1));
    lu_rd       = 5'($urandom_range(0, 31));
    lu_data     = $urandom;
  endtask

  task automatic drive_wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  task automatic drive_lu(input logic [4:0] rd, input logic [XLEN-1:0] d);
    lu_valid = 1'b1; lu_rd = rd; lu_data = d;
  endtask

  task automatic drive_issue(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic rd_we);
    issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_rd = rd; issue_rd_we = rd_we;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [XLEN-1:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {27'd0, rf_wR, rf_wD}, 64'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check_eq("rf_write", {27'd0, rf_wR, rf_wD}, {27'd0, e});
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    // 1: reset with random inputs, then no stale grant
    rst = 1'b1;
    drive_random();
    tick();
    drive_random();
    sample();
    check_eq("rst_rf_we", 64'(rf_we), 64'd0);
    check_eq("rst_busy", 64'(busy_vec), 64'd0);
    tick();
    rst = 1'b0;
    drive_idle();
    sample();
    check_eq("post_rst_rf_we", 64'(rf_we), 64'd0);
    check_eq("post_rst_wb_ready", 64'(wb_ready), 64'd1);
    check_eq("post_rst_lu_ready", 64'(lu_ready), 64'd0);
    check_eq("post_rst_stall", 64'(issue_stall), 64'd0);
    check_eq("post_rst_port", {27'd0, rf_wR, rf_wD}, 64'd0);

    // 2: RAW on x5 until LU writes it
    tick();
    drive_issue(5'd0, 5'd0, 5'd5, 1'b1);
    sample();
    check_eq("raw_first_issue", 64'(issue_stall), 64'd0);
    tick();
    drive_issue(5'd5, 5'd0, 5'd0, 1'b0);
    sample();
    check_eq("raw_busy5", 64'(busy_vec), 64'h20);
    check_eq("raw_stall_a", 64'(issue_stall), 64'd1);
    tick();
    sample();
    check_eq("raw_stall_b", 64'(issue_stall), 64'd1);
    tick();
    drive_lu(5'd5, 32'hA5A5_0005);
    expect_write(5'd5, 32'hA5A5_0005);
    sample();
    check_eq("raw_lu_ready", 64'(lu_ready), 64'd1);
`ifdef RF_SCHED_BYPASS_EN
    check_eq("raw_bypass_stall", 64'(issue_stall), 64'd0);
    check_eq("raw_bypass_fwd1", 64'(fwd_rs1), 64'd1);
`else
    check_eq("raw_nobypass_stall", 64'(issue_stall), 64'd1);
    check_eq("raw_nobypass_fwd1", 64'(fwd_rs1), 64'd0);
`endif
    tick();
    lu_valid = 1'b0;
    sample();
    check_eq("raw_busy_clear", 64'(busy_vec), 64'd0);
    check_eq("raw_released", 64'(issue_stall), 64'd0);
    tick();
    drive_idle();
    sample();

    // 3: starvation, WB wins 4 cycles then LU forced
    for (int i = 0; i < 4; i++) begin
      tick();
      drive_wb(5'(i + 1), 32'hB000_0000 + 32'(i));
      drive_lu(5'd12, 32'hC0DE_0012);
      expect_write(5'(i + 1), 32'hB000_0000 + 32'(i));
      sample();
      check_eq($sformatf("starve_wb_ready_%0d", i), 64'(wb_ready), 64'd1);
      check_eq($sformatf("starve_lu_ready_%0d", i), 64'(lu_ready), 64'd0);
    end
    tick();
    drive_wb(5'd20, 32'hB000_0020);
    expect_write(5'd12, 32'hC0DE_0012);
    sample();
    check_eq("force_lu_ready", 64'(lu_ready), 64'd1);
    check_eq("force_wb_ready", 64'(wb_ready), 64'd0);
    tick();
    lu_valid = 1'b0;
    expect_write(5'd20, 32'hB000_0020);
    sample();
    check_eq("after_force_wb_ready", 64'(wb_ready), 64'd1);
    check_eq("after_force_lu_ready", 64'(lu_ready), 64'd0);
    tick();
    drive_idle();
    sample();
    check_eq("starve_busy", 64'(busy_vec), 64'd0);

    // 4: same-cycle set and clear of x7, then WAW
    tick();
    drive_wb(5'd7, 32'h7777_0001);
    expect_write(5'd7, 32'h7777_0001);
    drive_issue(5'd0, 5'd0, 5'd7, 1'b1);
    sample();
    check_eq("setwin_stall", 64'(issue_stall), 64'd0);
    tick();
    drive_idle();
    sample();
    check_eq("set_wins", 64'(busy_vec), 64'h80);
    tick();
    drive_issue(5'd0, 5'd0, 5'd7, 1'b1);
    sample();
    check_eq("waw_stall", 64'(issue_stall), 64'd1);
    tick();
    drive_wb(5'd7, 32'h7777_0002);
    expect_write(5'd7, 32'h7777_0002);
    sample();
    check_eq("waw_during_write", 64'(issue_stall), 64'd1);
    tick();
    wb_valid = 1'b0;
    sample();
    check_eq("waw_release", 64'(issue_stall), 64'd0);
    check_eq("waw_busy_clear", 64'(busy_vec), 64'd0);
    tick();
    drive_idle();
    drive_lu(5'd7, 32'h7777_0003);
    expect_write(5'd7, 32'h7777_0003);
    sample();
    check_eq("waw_reissued", 64'(busy_vec), 64'h80);
    tick();
    drive_idle();
    sample();
    check_eq("x7_clear", 64'(busy_vec), 64'd0);

    // 5: x0 writes and issue
    tick();
    drive_wb(5'd0, 32'hDEAD_0000);
    drive_issue(5'd0, 5'd0, 5'd0, 1'b1);
    sample();
    check_eq("x0_wb_we", 64'(rf_we), 64'd0);
    check_eq("x0_stall", 64'(issue_stall), 64'd0);
    tick();
    drive_idle();
    drive_lu(5'd0, 32'hBEEF_0000);
    sample();
    check_eq("x0_lu_ready", 64'(lu_ready), 64'd1);
    check_eq("x0_lu_we", 64'(rf_we), 64'd0);
    check_eq("x0_busy", 64'(busy_vec), 64'd0);

    // 6: rs2 matches the write in flight this cycle
    tick();
    drive_idle();
    drive_issue(5'd0, 5'd0, 5'd9, 1'b1);
    sample();
    check_eq("byp_first_issue", 64'(issue_stall), 64'd0);
    tick();
    drive_issue(5'd0, 5'd9, 5'd0, 1'b0);
    drive_lu(5'd9, 32'h9999_0009);
    expect_write(5'd9, 32'h9999_0009);
    sample();
    check_eq("byp_busy9", 64'(busy_vec), 64'h200);
    check_eq("byp_fwd1", 64'(fwd_rs1), 64'd0);
`ifdef RF_SCHED_BYPASS_EN
    check_eq("byp_stall", 64'(issue_stall), 64'd0);
    check_eq("byp_fwd2", 64'(fwd_rs2), 64'd1);
`else
    check_eq("nobyp_stall", 64'(issue_stall), 64'd1);
    check_eq("nobyp_fwd2", 64'(fwd_rs2), 64'd0);
`endif
    tick();
    lu_valid = 1'b0;
    sample();
    check_eq("byp_after_stall", 64'(issue_stall), 64'd0);
    check_eq("byp_after_busy", 64'(busy_vec), 64'd0);
    check_eq("byp_after_fwd2", 64'(fwd_rs2), 64'd0);
    tick();
    drive_idle();
    sample();

    // random single-requester writes to untracked registers
    for (int i = 0; i < 24; i++) begin
      int unsigned sel;
      logic [4:0] rd;
      logic [XLEN-1:0] d;
      tick();
      drive_idle();
      sel = $urandom_range(0, 2);
      rd  = 5'($urandom_range(0, 31));
      d   = $urandom;
      if (sel == 1) drive_wb(rd, d);
      if (sel == 2) drive_lu(rd, d);
      if (sel != 0 && rd != 5'd0) expect_write(rd, d);
      sample();
    end
    tick();
    drive_idle();
    sample();
    check_eq("idle_port", {27'd0, rf_wR, rf_wD}, 64'd0);
    check_eq("final_busy", 64'(busy_vec), 64'd0);
    tick();
    check_eq("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
